sr_cmd_sequencer: RTL and testbench

Upstream command stage for the SR flip-flop (`SR_FF`). It accepts asynchronous-in-time set/clear requests from control logic and buffers them in a small FIFO. It then drives the flop's S and R inputs as isolated one-cycle pulses, and confirms each command against the flop's Q output. S and R are never asserted together, so the flop's forbidden S=R=1 input is unreachable by construction.

---
 rtl/sr_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: buffers set/clear requests in a small FIFO and replays
// them to an SR flop as isolated one-cycle S or R pulses. Each pulse is
// confirmed against the flop's Q (or times out), followed by an idle gap.
// S and R come from one command bit and are never high together.
module sr_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_req,
    input  logic                   clr_req,
    input  logic                   q_fb,
    output logic                   S,
    output logic                   R,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   ovf,
    output logic                   conflict,
    output logic                   tmo
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            cmd_q, cmd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            ovf_q, ovf_d;
    logic            conflict_q, conflict_d;
    logic            tmo_q, tmo_d;

    logic            is_full;
    logic            req_one;
    logic            push;
    logic            pop;
    logic            head;

    // Next-state: FIFO push/pop bookkeeping, sticky flags and the pulse FSM
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        conflict_d = conflict_q;
        tmo_d      = tmo_q;
        s_d        = 1'b0;
        r_d        = 1'b0;

        is_full = (count_q == FULL_CNT);
        req_one = set_req ^ clr_req;
        head    = mem_q[rd_ptr_q];
        // A pop only happens from IDLE, so a full FIFO can still accept on
        // the edge that frees a slot.
        pop     = (state_q == ST_IDLE) && (count_q != '0);
        push    = req_one && (!is_full || pop);

        if (set_req && clr_req)
            conflict_d = 1'b1;
        if (req_one && is_full && !pop)
            ovf_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = set_req;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    // Pulse is registered on the same edge DRIVE is entered
                    cmd_d   = head;
                    s_d     = head;
                    r_d     = ~head;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (q_fb == cmd_q) begin
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else if (int'(cnt_q) >= TIMEOUT - 1) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (int'(cnt_q) >= GAP - 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards the FIFO, pending command and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_q      <= 1'b0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            ovf_q      <= 1'b0;
            conflict_q <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            conflict_q <= conflict_d;
            tmo_q      <= tmo_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign count    = count_q;
    assign full     = (count_q == FULL_CNT);
    assign ovf      = ovf_q;
    assign conflict = conflict_q;
    assign tmo      = tmo_q;
    assign busy     = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Bench for sr_cmd_sequencer: a timeline model (command queue plus the edge
// at which the sequencer may next pop) predicts occupancy, flags and the
// edge of every S/R pulse; a negedge monitor compares against the DUT.
module tb_sr_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_req = 1'b0;
    logic       clr_req = 1'b0;
    logic       q_fb;
    logic       S, R, busy, full, ovf, conflict, tmo;
    logic [2:0] count;

    always #5 clk = ~clk;

    sr_cmd_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req), .q_fb(q_fb),
        .S(S), .R(R), .busy(busy), .count(count), .full(full),
        .ovf(ovf), .conflict(conflict), .tmo(tmo)
    );

    // Downstream SR flop; 'stuck' forces its Q output low
    logic q_ff = 1'b0;
    bit   stuck = 1'b0;
    always @(posedge clk) begin
        if (S) q_ff <= 1'b1;
        else if (R) q_ff <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : q_ff;

    typedef struct { bit cmd; int edge_n; } pulse_t;
    pulse_t exp_q[$];
    bit     mq[$];
    int     cyc = 0;
    int     next_pop = 0;
    int     tmo_edge = -1;
    bit     ovf_m = 0, conf_m = 0, tmo_m = 0, armed = 0;
    int     errors = 0, checks = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endfunction

    // Reference model: one pop per command period; period length depends
    // only on whether Q can reach the commanded value.
    always @(posedge clk) begin
        bit     pop_m, full_before;
        pulse_t p;
        cyc++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            next_pop = cyc + 1;
            tmo_edge = -1;
            ovf_m = 0; conf_m = 0; tmo_m = 0;
            armed = 1;
        end else if (armed) begin
            full_before = (mq.size() == DEPTH);
            pop_m = (mq.size() > 0) && (cyc >= next_pop);
            if (pop_m) begin
                p.cmd = mq.pop_front();
                p.edge_n = cyc;
                exp_q.push_back(p);
                if (stuck && p.cmd) begin
                    tmo_edge = cyc + 1 + TIMEOUT;
                    next_pop = cyc + 2 + TIMEOUT + GAP;
                end else begin
                    next_pop = cyc + 3 + GAP;
                end
            end
            if (set_req && clr_req) conf_m = 1;
            else if (set_req || clr_req) begin
                if (!full_before || pop_m) mq.push_back(set_req);
                else ovf_m = 1;
            end
            if (tmo_edge == cyc) tmo_m = 1;
        end
    end

    // Monitor: compare outputs mid-cycle, pop scoreboard on pulse cycles
    always @(negedge clk) begin
        pulse_t p;
        bit     idle_m;
        if (armed) begin
            chk("s_r_exclusive", int'(S && R), 0);
            chk("count", int'(count), mq.size());
            chk("full", int'(full), int'(mq.size() == DEPTH));
            idle_m = (cyc >= next_pop - 1);
            chk("busy", int'(busy), int'((mq.size() > 0) || !idle_m));
            chk("ovf", int'(ovf), int'(ovf_m));
            chk("conflict", int'(conflict), int'(conf_m));
            chk("tmo", int'(tmo), int'(tmo_m));
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                p = exp_q.pop_front();
                chk("pulse_S", int'(S), int'(p.cmd));
                chk("pulse_R", int'(R), int'(!p.cmd));
            end else begin
                chk("no_pulse", int'(S || R), 0);
            end
        end
    end

    task automatic req(input bit s, input bit c);
        set_req = s;
        clr_req = c;
        @(negedge clk);
        set_req = 0;
        clr_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() > 0 || cyc < next_pop - 1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", int'(n < 500), 1);
    endtask

    initial begin
        int rv;
        @(negedge clk);
        rst = 1;
        idle(2);
        rst = 0;
        idle(1);
        // single set
        req(1, 0); drain(); idle(2);
        // queue of four alternating commands
        req(1, 0); req(0, 1); req(1, 0); req(0, 1); drain(); idle(1);
        // conflicting request
        req(1, 1); idle(3); drain();
        // stuck flop: overflow plus timeouts
        stuck = 1;
        repeat (6) req(1, 0);
        drain();
        stuck = 0;
        idle(2);
        // redundant set (flop already 1)
        req(1, 0); drain(); idle(1);
        // reset while in WAIT with two pending
        req(1, 0); req(1, 0); req(1, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        idle(2);
        // random traffic with occasional resets
        repeat (400) begin
            rv = int'($urandom_range(0, 199));
            rst     = (rv == 0);
            set_req = (rv >= 1 && rv <= 30) || (rv >= 190);
            clr_req = (rv >= 31 && rv <= 60) || (rv >= 195);
            @(negedge clk);
        end
        rst = 0; set_req = 0; clr_req = 0;
        drain();
        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
